// File: rtl/sar_n_if.sv
// Conversion handshake and datapath bundle for the sar_n successive-approximation controller.
interface sar_n_if #(
  parameter int unsigned WIDTH = 5
);
  logic             start;
  logic             cont;
  logic             comp;
  logic [WIDTH-1:0] dac;
  logic [WIDTH-1:0] out;
  logic             sar_serial;
  logic             bit_valid;
  logic             start_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, cont, comp,
    input  dac, out, sar_serial, bit_valid, start_ready, busy, done
  );

  modport slave (
    input  start, cont, comp,
    output dac, out, sar_serial, bit_valid, start_ready, busy, done
  );
endinterface

// File: rtl/sar_n.sv
// WIDTH-bit successive-approximation controller with start handshake, continuous mode,
// programmable comparator settle delay, and parallel plus MSB-first serial result.
module sar_n #(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input logic    clk,
  input logic    reset,
  sar_n_if.slave bus
);
  localparam int unsigned      IW          = $clog2(WIDTH);
  localparam logic [IW-1:0]    IDX_TOP     = IW'(WIDTH - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONV,
    ST_DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] dac_q;
  logic [WIDTH-1:0] out_q;
  logic             serial_q;
  logic             bit_valid_q;
  logic             start_ready_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] next_trial;

  // Bits below idx are still zero, so OR-ing in the decision and the next trial bit suffices.
  always_comb begin
    decided = result;
    if (bus.comp) begin
      decided = result | (ONE << idx);
    end
    next_trial = decided | (ONE << (idx - 1'b1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= IDX_TOP;
      settle_cnt    <= '0;
      result        <= '0;
      dac_q         <= '0;
      out_q         <= '0;
      serial_q      <= 1'b0;
      bit_valid_q   <= 1'b0;
      start_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      start_ready_q <= 1'b0;
      bit_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      case (state)
        ST_IDLE: begin
          dac_q <= '0;
          if (bus.start) begin
            state         <= ST_SAMPLE;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          state      <= ST_CONV;
          result     <= '0;
          idx        <= IDX_TOP;
          settle_cnt <= '0;
          dac_q      <= ONE << IDX_TOP;
        end
        ST_CONV: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt  <= '0;
            result      <= decided;
            serial_q    <= bus.comp;
            bit_valid_q <= 1'b1;
            if (idx == '0) begin
              state  <= ST_DONE;
              out_q  <= decided;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              dac_q  <= '0;
            end else begin
              idx   <= idx - 1'b1;
              dac_q <= next_trial;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          dac_q <= '0;
          if (bus.cont || bus.start) begin
            state         <= ST_SAMPLE;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dac         = dac_q;
  assign bus.out         = out_q;
  assign bus.sar_serial  = serial_q;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.start_ready = start_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_sar_n.sv
// Directed bench for sar_n: three instances (5-bit, 5-bit with settle delay, 12-bit).
module tb_sar_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sar_n_if #(.WIDTH(5))  a_if ();
  sar_n_if #(.WIDTH(5))  b_if ();
  sar_n_if #(.WIDTH(12)) c_if ();

  sar_n #(.WIDTH(5),  .SETTLE_CYCLES(0)) u_a (.clk(clk), .reset(rst), .bus(a_if));
  sar_n #(.WIDTH(5),  .SETTLE_CYCLES(2)) u_b (.clk(clk), .reset(rst), .bus(b_if));
  sar_n #(.WIDTH(12), .SETTLE_CYCLES(0)) u_c (.clk(clk), .reset(rst), .bus(c_if));

  // Comparator model: analog input expressed as a code; optional override for forced patterns.
  int   a_vin = 0, b_vin = 0, c_vin = 0;
  logic a_force = 1'b0, a_force_val = 1'b0;
  logic b_force = 1'b0, b_force_val = 1'b0;
  assign a_if.comp = a_force ? a_force_val : (a_vin >= int'(a_if.dac));
  assign b_if.comp = b_force ? b_force_val : (b_vin >= int'(b_if.dac));
  assign c_if.comp = (c_vin >= int'(c_if.dac));

  task automatic test_reset();
    #2;
    n_vec++; if ({a_if.dac, a_if.out, a_if.sar_serial, a_if.bit_valid, a_if.start_ready, a_if.busy, a_if.done} !== '0) begin
      n_bad++; $display("FAIL reset_a: got %h expected 0", {a_if.dac, a_if.out, a_if.sar_serial, a_if.bit_valid, a_if.start_ready, a_if.busy, a_if.done});
    end
    n_vec++; if ({b_if.dac, b_if.out, b_if.sar_serial, b_if.bit_valid, b_if.start_ready, b_if.busy, b_if.done} !== '0) begin
      n_bad++; $display("FAIL reset_b: got %h expected 0", {b_if.dac, b_if.out, b_if.sar_serial, b_if.bit_valid, b_if.start_ready, b_if.busy, b_if.done});
    end
    n_vec++; if ({c_if.dac, c_if.out, c_if.sar_serial, c_if.bit_valid, c_if.start_ready, c_if.busy, c_if.done} !== '0) begin
      n_bad++; $display("FAIL reset_c: got %h expected 0", {c_if.dac, c_if.out, c_if.sar_serial, c_if.bit_valid, c_if.start_ready, c_if.busy, c_if.done});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_midscale();
    int         exp_dac [8] = '{0, 16, 24, 20, 18, 19, 0, 0};
    logic [7:0] exp_bv   = 8'b0111_1100;
    logic [7:0] exp_ser  = 8'b0110_0100;
    logic [7:0] exp_busy = 8'b0011_1111;
    logic [7:0] exp_sr   = 8'b0000_0001;
    logic [7:0] exp_done = 8'b0100_0000;
    int busy_cnt = 0, sr_at = -1, done_at = -1;
    a_vin = 19;
    @(negedge clk); a_if.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_if.start = 1'b0;
      n_vec++; if (a_if.dac !== 5'(exp_dac[i])) begin n_bad++; $display("FAIL mid_dac[%0d]: got %0d expected %0d", i, a_if.dac, exp_dac[i]); end
      n_vec++; if (a_if.bit_valid !== exp_bv[i]) begin n_bad++; $display("FAIL mid_bv[%0d]: got %b expected %b", i, a_if.bit_valid, exp_bv[i]); end
      if (exp_bv[i]) begin
        n_vec++; if (a_if.sar_serial !== exp_ser[i]) begin n_bad++; $display("FAIL mid_ser[%0d]: got %b expected %b", i, a_if.sar_serial, exp_ser[i]); end
      end
      n_vec++; if (a_if.busy !== exp_busy[i]) begin n_bad++; $display("FAIL mid_busy[%0d]: got %b expected %b", i, a_if.busy, exp_busy[i]); end
      n_vec++; if (a_if.start_ready !== exp_sr[i]) begin n_bad++; $display("FAIL mid_sr[%0d]: got %b expected %b", i, a_if.start_ready, exp_sr[i]); end
      n_vec++; if (a_if.done !== exp_done[i]) begin n_bad++; $display("FAIL mid_done[%0d]: got %b expected %b", i, a_if.done, exp_done[i]); end
      if (exp_done[i]) begin
        n_vec++; if (a_if.out !== 5'd19) begin n_bad++; $display("FAIL mid_out: got %0d expected 19", a_if.out); end
      end
      if (a_if.busy === 1'b1) busy_cnt++;
      if (a_if.start_ready === 1'b1) sr_at = i;
      if (a_if.done === 1'b1) done_at = i;
    end
    n_vec++; if (busy_cnt != 6) begin n_bad++; $display("FAIL mid_busy_len: got %0d expected 6", busy_cnt); end
    n_vec++; if (done_at - sr_at != 6) begin n_bad++; $display("FAIL mid_latency: got %0d expected 6", done_at - sr_at); end
  endtask

  task automatic test_full_scale();
    int seq [2][5] = '{'{16, 8, 4, 2, 1}, '{16, 24, 28, 30, 31}};
    int exp_out [2] = '{0, 31};
    for (int p = 0; p < 2; p++) begin
      a_force = 1'b1; a_force_val = (p == 1);
      @(negedge clk); a_if.start = 1'b1;
      @(negedge clk); a_if.start = 1'b0;
      for (int n = 2; n <= 7; n++) begin
        @(negedge clk);
        if (n <= 6) begin
          n_vec++; if (a_if.dac !== 5'(seq[p][n-2])) begin n_bad++; $display("FAIL fs%0d_dac[%0d]: got %0d expected %0d", p, n, a_if.dac, seq[p][n-2]); end
        end else begin
          n_vec++; if (a_if.done !== 1'b1) begin n_bad++; $display("FAIL fs%0d_done: got %b expected 1", p, a_if.done); end
          n_vec++; if (a_if.out !== 5'(exp_out[p])) begin n_bad++; $display("FAIL fs%0d_out: got %0d expected %0d", p, a_if.out, exp_out[p]); end
        end
      end
      @(negedge clk);
    end
    a_force = 1'b0;
  endtask

  task automatic test_settle();
    int         seq [5] = '{16, 24, 20, 18, 19};
    logic [4:0] bits = 5'b11001;
    b_vin = 19;
    @(negedge clk); b_if.start = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      b_if.start = 1'b0;
      if (n >= 2 && n <= 16) begin
        n_vec++; if (b_if.dac !== 5'(seq[(n-2)/3])) begin n_bad++; $display("FAIL st_dac[%0d]: got %0d expected %0d", n, b_if.dac, seq[(n-2)/3]); end
      end
      n_vec++; if (b_if.bit_valid !== (n >= 5 && (n - 2) % 3 == 0)) begin n_bad++; $display("FAIL st_bv[%0d]: got %b", n, b_if.bit_valid); end
      if (n >= 5 && (n - 2) % 3 == 0) begin
        n_vec++; if (b_if.sar_serial !== bits[(n-5)/3]) begin n_bad++; $display("FAIL st_ser[%0d]: got %b expected %b", n, b_if.sar_serial, bits[(n-5)/3]); end
      end
      n_vec++; if (b_if.done !== (n == 17)) begin n_bad++; $display("FAIL st_done[%0d]: got %b expected %b", n, b_if.done, n == 17); end
      if (n == 17) begin
        n_vec++; if (b_if.out !== 5'd19) begin n_bad++; $display("FAIL st_out: got %0d expected 19", b_if.out); end
      end
      // Wrong comparator level during the two settle cycles of every bit.
      if (n >= 2 && n <= 16 && (n - 2) % 3 < 2) begin
        b_force = 1'b1; b_force_val = !(b_vin >= int'(b_if.dac));
      end else begin
        b_force = 1'b0;
      end
    end
  endtask

  task automatic test_continuous();
    int conv2_dac [5] = '{16, 8, 4, 6, 7};
    a_vin = 19;
    @(negedge clk); a_if.start = 1'b1; a_if.cont = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      a_if.start = 1'b0;
      n_vec++; if (a_if.start_ready !== (n == 1 || n == 8 || n == 15)) begin n_bad++; $display("FAIL ct_sr[%0d]: got %b", n, a_if.start_ready); end
      n_vec++; if (a_if.done !== (n == 7 || n == 14 || n == 21)) begin n_bad++; $display("FAIL ct_done[%0d]: got %b", n, a_if.done); end
      if (n >= 7) begin
        n_vec++; if (a_if.out !== ((n < 14) ? 5'd16 : 5'd7)) begin n_bad++; $display("FAIL ct_out[%0d]: got %0d expected %0d", n, a_if.out, (n < 14) ? 16 : 7); end
      end
      if (n >= 9 && n <= 13) begin
        n_vec++; if (a_if.dac !== 5'(conv2_dac[n-9])) begin n_bad++; $display("FAIL ct_dac[%0d]: got %0d expected %0d", n, a_if.dac, conv2_dac[n-9]); end
      end
      if (n >= 22) begin
        n_vec++; if ({a_if.busy, a_if.dac} !== 6'd0) begin n_bad++; $display("FAIL ct_idle[%0d]: got busy=%b dac=%0d expected 0", n, a_if.busy, a_if.dac); end
      end
      if (n == 3) a_vin = 7;
      if (n == 17) a_if.cont = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int new_dac [5] = '{16, 8, 12, 10, 11};
    a_vin = 19;
    @(negedge clk); a_if.start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      a_if.start = 1'b0;
    end
    n_vec++; if (a_if.dac !== 5'd20) begin n_bad++; $display("FAIL rm_pre_dac: got %0d expected 20", a_if.dac); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (a_if.dac !== 5'd0) begin n_bad++; $display("FAIL rm_dac: got %0d expected 0", a_if.dac); end
    n_vec++; if (a_if.out !== 5'd0) begin n_bad++; $display("FAIL rm_out: got %0d expected 0", a_if.out); end
    n_vec++; if ({a_if.busy, a_if.bit_valid, a_if.sar_serial, a_if.start_ready, a_if.done} !== 5'd0) begin
      n_bad++; $display("FAIL rm_flags: got %b expected 00000", {a_if.busy, a_if.bit_valid, a_if.sar_serial, a_if.start_ready, a_if.done});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_vec++; if ({a_if.busy, a_if.start_ready, a_if.dac, a_if.out} !== '0) begin n_bad++; $display("FAIL rm_quiet[%0d]: got busy=%b sr=%b dac=%0d out=%0d expected 0", n, a_if.busy, a_if.start_ready, a_if.dac, a_if.out); end
    end
    a_vin = 11;
    a_if.start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      a_if.start = 1'b0;
      if (n >= 2 && n <= 6) begin
        n_vec++; if (a_if.dac !== 5'(new_dac[n-2])) begin n_bad++; $display("FAIL rm_dac2[%0d]: got %0d expected %0d", n, a_if.dac, new_dac[n-2]); end
      end
    end
    n_vec++; if ({a_if.done, a_if.out} !== {1'b1, 5'd11}) begin n_bad++; $display("FAIL rm_result: got done=%b out=%0d expected done=1 out=11", a_if.done, a_if.out); end
  endtask

  task automatic test_width12();
    int          seq [12] = '{2048, 3072, 2560, 2816, 2688, 2752, 2720, 2736, 2728, 2732, 2730, 2731};
    logic [11:0] bits = 12'hAAB;
    c_vin = 2731;
    @(negedge clk); c_if.start = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      n_vec++; if (c_if.start_ready !== (n == 1)) begin n_bad++; $display("FAIL w12_sr[%0d]: got %b", n, c_if.start_ready); end
      if (n >= 2 && n <= 13) begin
        n_vec++; if (c_if.dac !== 12'(seq[n-2])) begin n_bad++; $display("FAIL w12_dac[%0d]: got %0d expected %0d", n, c_if.dac, seq[n-2]); end
      end
      if (n >= 3 && n <= 14) begin
        n_vec++; if ({c_if.bit_valid, c_if.sar_serial} !== {1'b1, bits[14-n]}) begin n_bad++; $display("FAIL w12_ser[%0d]: got bv=%b ser=%b expected bv=1 ser=%b", n, c_if.bit_valid, c_if.sar_serial, bits[14-n]); end
      end
      n_vec++; if (c_if.done !== (n == 14)) begin n_bad++; $display("FAIL w12_done[%0d]: got %b", n, c_if.done); end
      if (n == 14) begin
        n_vec++; if (c_if.out !== 12'd2731) begin n_bad++; $display("FAIL w12_out: got %0d expected 2731", c_if.out); c_if.start = 1'b0; end
        c_if.start = 1'b0;
      end
      if (n >= 15) begin
        n_vec++; if (c_if.busy !== 1'b0) begin n_bad++; $display("FAIL w12_idle[%0d]: got busy=%b expected 0", n, c_if.busy); end
      end
    end
  endtask

  initial begin
    a_if.start = 1'b0; a_if.cont = 1'b0;
    b_if.start = 1'b0; b_if.cont = 1'b0;
    c_if.start = 1'b0; c_if.cont = 1'b0;
    test_reset();
    test_midscale();
    test_full_scale();
    test_settle();
    test_continuous();
    test_reset_mid();
    test_width12();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
